// File: rtl/idma_b_tracker_pkg.sv
`default_nettype none
// ============================================================================
// idma_b_tracker_pkg : shared types for the iDMA write-response tracker
// Revision 1.0
// ============================================================================
package idma_b_tracker_pkg;

  localparam int unsigned BURST_CNT_WIDTH_MAX = 32;
  localparam logic [1:0]  RESP_OKAY           = 2'b00;

  typedef struct packed {
    logic last;
    logic super_last;
  } b_fifo_entry_t;

  typedef struct packed {
    logic                           error;
    logic [1:0]                     resp;
    logic                           super_last;
    logic [BURST_CNT_WIDTH_MAX-1:0] num_bursts;
  } b_rsp_t;

  // Sticky first non-OKAY response: once captured it is never overwritten.
  function automatic logic [1:0] merge_resp(input logic [1:0] acc, input logic [1:0] cur);
    return (acc != RESP_OKAY) ? acc : cur;
  endfunction

endpackage
`default_nettype wire

// File: rtl/idma_b_tracker_fifo.sv
`default_nettype none
// ============================================================================
// idma_b_tracker_fifo : in-order circular buffer of outstanding write bursts
// Revision 1.0
// ============================================================================
module idma_b_tracker_fifo
  import idma_b_tracker_pkg::*;
#(
  parameter int unsigned Depth = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  b_fifo_entry_t                data_i,
  input  logic                         pop_i,
  output b_fifo_entry_t                data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(Depth+1)-1:0]   usage_o
);

  localparam int unsigned PTR_WIDTH = $clog2(Depth);
  localparam int unsigned CNT_WIDTH = $clog2(Depth+1);

  b_fifo_entry_t          mem_q [Depth];
  logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]   usage_q, usage_d;
  logic                   w_push, w_pop;

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] ptr);
    return (ptr == PTR_WIDTH'(Depth-1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full_o  = (usage_q == CNT_WIDTH'(Depth));
  assign empty_o = (usage_q == '0);
  assign usage_o = usage_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Push is gated by full only, so a same-cycle pop never frees a slot early.
  assign w_push = push_i & ~full_o;
  assign w_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usage_d  = usage_q;
    if (w_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (w_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    unique case ({w_push, w_pop})
      2'b10:   usage_d = usage_q + 1'b1;
      2'b01:   usage_d = usage_q - 1'b1;
      default: usage_d = usage_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usage_q  <= usage_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else if (w_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/idma_b_tracker.sv
`default_nettype none
// ============================================================================
// idma_b_tracker : collects AXI B responses per 1D transfer into one completion
// Revision 1.0
// ============================================================================
module idma_b_tracker
  import idma_b_tracker_pkg::*;
#(
  parameter int unsigned NumAxInFlight = 8,
  parameter int unsigned BurstCntWidth = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 req_valid_i,
  output logic                                 req_ready_o,
  input  logic                                 req_last_i,
  input  logic                                 req_super_last_i,
  input  logic                                 b_valid_i,
  input  logic [1:0]                           b_resp_i,
  output logic                                 b_ready_o,
  output logic                                 rsp_valid_o,
  input  logic                                 rsp_ready_i,
  output logic                                 rsp_error_o,
  output logic [1:0]                           rsp_resp_o,
  output logic                                 rsp_super_last_o,
  output logic [BurstCntWidth-1:0]             rsp_num_bursts_o,
  output logic [$clog2(NumAxInFlight+1)-1:0]   outstanding_o,
  output logic                                 busy_o
);

  b_fifo_entry_t          w_push_entry, w_head;
  logic                   w_full, w_empty, w_b_hs;
  logic [BurstCntWidth-1:0] w_cnt_inc;

  logic                     err_q, err_d;
  logic [1:0]               resp_q, resp_d;
  logic [BurstCntWidth-1:0] cnt_q, cnt_d;
  b_rsp_t                   rsp_q, rsp_d;
  logic                     rsp_valid_q, rsp_valid_d;

  assign w_push_entry = '{last: req_last_i, super_last: req_super_last_i};

  idma_b_tracker_fifo #(
    .Depth (NumAxInFlight)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (req_valid_i),
    .data_i  (w_push_entry),
    .pop_i   (w_b_hs),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .usage_o (outstanding_o)
  );

  assign req_ready_o = ~w_full;
  // A final burst may only complete when the response register can take it.
  assign b_ready_o   = ~w_empty & (~w_head.last | ~rsp_valid_q | rsp_ready_i);
  assign w_b_hs      = b_valid_i & b_ready_o;
  assign w_cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    err_d       = err_q;
    resp_d      = resp_q;
    cnt_d       = cnt_q;
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q;
    if (rsp_valid_q & rsp_ready_i) rsp_valid_d = 1'b0;
    if (w_b_hs) begin
      if (w_head.last) begin
        rsp_d.error      = err_q | b_resp_i[1];
        rsp_d.resp       = merge_resp(resp_q, b_resp_i);
        rsp_d.super_last = w_head.super_last;
        rsp_d.num_bursts = BURST_CNT_WIDTH_MAX'(w_cnt_inc);
        rsp_valid_d      = 1'b1;
        err_d            = 1'b0;
        resp_d           = RESP_OKAY;
        cnt_d            = '0;
      end else begin
        err_d  = err_q | b_resp_i[1];
        resp_d = merge_resp(resp_q, b_resp_i);
        cnt_d  = w_cnt_inc;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q       <= 1'b0;
      resp_q      <= RESP_OKAY;
      cnt_q       <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      err_q       <= err_d;
      resp_q      <= resp_d;
      cnt_q       <= cnt_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_error_o      = rsp_q.error;
  assign rsp_resp_o       = rsp_q.resp;
  assign rsp_super_last_o = rsp_q.super_last;
  assign rsp_num_bursts_o = rsp_q.num_bursts[BurstCntWidth-1:0];
  assign busy_o           = ~w_empty | (cnt_q != '0) | rsp_valid_q;

`ifndef SYNTHESIS
  if (BurstCntWidth < BURST_CNT_WIDTH_MAX) begin : g_cnt_pad
    logic [BURST_CNT_WIDTH_MAX-BurstCntWidth-1:0] w_cnt_pad;
    assign w_cnt_pad = rsp_q.num_bursts[BURST_CNT_WIDTH_MAX-1:BurstCntWidth];
    a_cnt_pad_zero : assert property (@(posedge clk_i) w_cnt_pad == '0);
  end

  a_b_without_burst : assert property (@(posedge clk_i) disable iff (rst_i)
    b_valid_i |-> !w_empty);
  a_req_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (req_valid_i && !req_ready_o) |=> (req_valid_i && $stable({req_last_i, req_super_last_i})));
  a_b_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (b_valid_i && !b_ready_o) |=> (b_valid_i && $stable(b_resp_i)));
`endif

endmodule
`default_nettype wire

// File: doc/idma_b_tracker.md
IDMA_B_TRACKER -- requirements
Module: idma_b_tracker

Interface
REQ-001 SHALL have parameter NumAxInFlight, default 8, giving the maximum number of outstanding write bursts (at least 2).
REQ-002 SHALL have parameter BurstCntWidth, default 16, giving the width of the per-transfer burst counter.
REQ-003 SHALL have port clk_i, input, 1, the single clock.
REQ-004 SHALL have port rst_i, input, 1: reset is asynchronous and active-high.
REQ-005 SHALL have port req_valid_i, input, 1, write burst issued by the legalizer.
REQ-006 SHALL have port req_ready_o, output, 1, burst slot available.
REQ-007 SHALL have port req_last_i, input, 1, the burst is the last of its 1D transfer.
REQ-008 SHALL have port req_super_last_i, input, 1, the transfer is the last one of a midend job.
REQ-009 SHALL have port b_valid_i, input, 1, AXI B valid.
REQ-010 SHALL have port b_resp_i, input, 2, AXI BRESP.
REQ-011 SHALL have port b_ready_o, output, 1, AXI B ready.
REQ-012 SHALL have port rsp_valid_o, output, 1, 1D transfer completed.
REQ-013 SHALL have port rsp_ready_i, input, 1, completion accepted.
REQ-014 SHALL have port rsp_error_o, output, 1, at least one burst of the transfer returned SLVERR or DECERR.
REQ-015 SHALL have port rsp_resp_o, output, 2, the first non-OKAY BRESP of the transfer, or OKAY.
REQ-016 SHALL have port rsp_super_last_o, output, 1, the super_last flag of the completed transfer.
REQ-017 SHALL have port rsp_num_bursts_o, output, BurstCntWidth, the number of B responses of the transfer.
REQ-018 SHALL have port outstanding_o, output, $clog2(NumAxInFlight+1), the FIFO occupancy.
REQ-019 SHALL have port busy_o, output, 1, high when occupancy != 0, a burst is being accumulated, or rsp_valid_o is high.

Function
REQ-020 SHALL store {last, super_last} per accepted burst in an in-order FIFO of depth NumAxInFlight.
REQ-021 SHALL drive req_ready_o = !full, so a push is never accepted while full, even when a pop occurs in the same cycle.
REQ-022 SHALL allow a push and a pop in the same cycle when not full; occupancy is then unchanged.
REQ-023 SHALL drive b_ready_o = !empty & (!head.last | !rsp_valid_o | rsp_ready_i).
REQ-024 SHALL pop the FIFO head on each B handshake (b_valid_i & b_ready_o).
REQ-025 SHALL hold accumulators err_q, resp_q and cnt_q across B handshakes of one transfer.
REQ-026 SHALL set err_q on a B handshake with b_resp_i[1]=1.
REQ-027 SHALL load resp_q from the first non-OKAY b_resp_i of the transfer (EXOKAY counts as non-OKAY); later responses do not change it.
REQ-028 SHALL increment cnt_q per B handshake, saturating at 2^BurstCntWidth-1.
REQ-029 SHALL, on a B handshake of a head with last=1, load the response register with the accumulators merged with the current beat, raise rsp_valid_o in the next cycle, and clear the accumulators in the same edge.
REQ-030 SHALL have a completion latency of exactly 1 cycle from the final B handshake to rsp_valid_o.
REQ-031 SHALL hold rsp_valid_o and all rsp_* outputs stable until rsp_ready_i; rsp_valid_o clears on handshake unless a new completion loads in the same cycle (back-to-back completions without bubble).
REQ-032 SHALL keep b_ready_o low while empty; a B response with no outstanding burst is illegal and is flagged by an assertion.
REQ-033 SHALL flag by assertion a change of req_* while req_valid_i & !req_ready_o, and a change of b_resp_i while b_valid_i & !b_ready_o.

Reset
REQ-034 SHALL, on rst_i assertion at any time, including mid-transfer, immediately empty the FIFO, clear the accumulators and the response register, and drive rsp_valid_o=0, b_ready_o=0, req_ready_o=1 (while out of reset), outstanding_o=0, busy_o=0, rsp_error_o=0, rsp_resp_o=0, rsp_super_last_o=0 and rsp_num_bursts_o=0.
REQ-035 SHALL resume normal operation on the first clock edge after rst_i deasserts; pending B responses from before reset are the system's responsibility.

Structure
REQ-036 SHALL place the FIFO entry type {last, super_last} and the response struct {error, resp, super_last, num_bursts} in the shared idma package.
REQ-037 SHALL implement the FIFO as one sub-module, idma_b_tracker_fifo: a pointer-based circular buffer with an occupancy counter and correct pointer wrap-around at NumAxInFlight-1.

Verification
REQ-038 SHALL test a 3-burst transfer (last=0,0,1) with BRESP OKAY,OKAY,OKAY -> one rsp 1 cycle after 3rd B: error=0, resp=0, num_bursts=3.
REQ-039 SHALL test BRESP OKAY,SLVERR,DECERR on a 3-burst transfer -> error=1, resp=2'b10, num_bursts=3.
REQ-040 SHALL test pushing 8 bursts without B -> req_ready_o=0 and outstanding_o=8; then one B -> req_ready_o=1 next cycle, and a push in the pop cycle is refused.
REQ-041 SHALL test two single-burst transfers with rsp_ready_i=0 -> first rsp is held, and b_ready_o=0 for the second last burst until rsp_ready_i=1, then the second rsp follows with no bubble.
REQ-042 SHALL test rst_i asserted after the 2nd of 3 B responses -> all outputs are at reset values asynchronously; a fresh single-burst transfer then gives num_bursts=1.
REQ-043 SHALL test 20 random-length transfers through a full FIFO wrap twice -> response order and super_last match the order pushed.
